// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_datapath.sv
// Iterative shift-add multiply / restoring divide, one step per cycle.
// Divide step is built only with MUL_DIV_UNIT_DIV_EN; otherwise DIV yields zero.
module mul_div_datapath
    import mul_div_pkg::*;
#(
    parameter int OPW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  op_e              op,
    input  logic [OPW-1:0]   op_a,
    input  logic [OPW-1:0]   op_b,
    output logic             last,
    output logic [2*OPW-1:0] result
);
    localparam int CW = $clog2(OPW + 1);

    // acc holds the product high half / partial remainder; sh holds the
    // multiplier being consumed / the dividend turning into the quotient.
    op_e            op_r;
    logic [OPW-1:0] b_r;
    logic [OPW-1:0] acc;
    logic [OPW-1:0] sh;
    logic [CW-1:0]  cnt;
    logic [OPW:0]   mul_sum;
    logic [OPW-1:0] acc_nxt;
    logic [OPW-1:0] sh_nxt;

    assign mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, b_r} : '0);
    assign last    = (cnt == CW'(OPW - 1));

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [OPW:0] rem_sh;
    assign rem_sh = {acc, sh[OPW-1]};

    // A zero divisor always "fits", giving all-ones quotient and rem = dividend.
    always_comb begin
        acc_nxt = mul_sum[OPW:1];
        sh_nxt  = {mul_sum[0], sh[OPW-1:1]};
        if (op_r == OP_DIV) begin
            if (rem_sh >= {1'b0, b_r}) begin
                acc_nxt = OPW'(rem_sh - {1'b0, b_r});
                sh_nxt  = {sh[OPW-2:0], 1'b1};
            end else begin
                acc_nxt = rem_sh[OPW-1:0];
                sh_nxt  = {sh[OPW-2:0], 1'b0};
            end
        end
    end

    assign result = {acc, sh};
`else
    always_comb begin
        acc_nxt = mul_sum[OPW:1];
        sh_nxt  = {mul_sum[0], sh[OPW-1:1]};
    end

    assign result = (op_r == OP_DIV) ? '0 : {acc, sh};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r <= OP_MUL;
            b_r  <= '0;
            acc  <= '0;
            sh   <= '0;
            cnt  <= '0;
        end else if (load) begin
            op_r <= op;
            b_r  <= (op == OP_DIV) ? op_b : op_a;
            acc  <= '0;
            sh   <= (op == OP_DIV) ? op_a : op_b;
            cnt  <= '0;
        end else if (step) begin
            acc  <= acc_nxt;
            sh   <= sh_nxt;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Unsigned multiply/divide unit with register-file writeback handshake.
// Divide datapath is present only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int OPW  = 16,
    parameter int RESW = 2 * OPW,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic [OPW-1:0]  op_a,
    input  logic [OPW-1:0]  op_b,
    input  logic [IDXW-1:0] dest,
    output logic            wb_en,
    output logic [RESW-1:0] wb_data,
    output logic [IDXW-1:0] wb_reg,
    output logic            busy
);
    state_e             state;
    state_e             state_nxt;
    logic               accept;
    logic               last;
    logic [2*OPW-1:0]   result;
    logic [IDXW-1:0]    dest_r;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last)   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
        wb_en    = (state == S_DONE);
    end

    // Index is held with the result until the next request replaces it.
    always_ff @(posedge clk) begin
        if (rst)         dest_r <= '0;
        else if (accept) dest_r <= dest;
    end

    mul_div_datapath #(
        .OPW(OPW)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == S_RUN),
        .op     (op_e'(op)),
        .op_a   (op_a),
        .op_b   (op_b),
        .last   (last),
        .result (result)
    );

    assign wb_data = RESW'(result);
    assign wb_reg  = dest_r;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter OPW, default 16, meaning operand width; matches register-file read-port width.
REQ-002 SHALL have parameter RESW, default 2*OPW, meaning result width; matches register-file write-data width.
REQ-003 SHALL have parameter IDXW, default 4, meaning destination register index width (16 registers).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operation request.
REQ-007 SHALL have port in_ready  output  1  unit can accept a request.
REQ-008 SHALL have port op  input  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-009 SHALL have port op_a  input  OPW  multiplicand or dividend (register-file port A).
REQ-010 SHALL have port op_b  input  OPW  multiplier or divisor (register-file port B).
REQ-011 SHALL have port dest  input  IDXW  destination register index.
REQ-012 SHALL have port wb_en  output  1  one-cycle write strobe to the register-file write enable.
REQ-013 SHALL have port wb_data  output  RESW  result to the register-file write data.
REQ-014 SHALL have port wb_reg  output  IDXW  destination index to the register-file write index.
REQ-015 SHALL have port busy  output  1  high while an operation is in flight (RUN or DONE).

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 SHALL drive in_ready high only in IDLE.
REQ-018 SHALL accept a request on the edge where in_valid && in_ready, capturing op, op_a, op_b and dest; in_valid outside IDLE is ignored.
REQ-019 SHALL iterate exactly OPW cycles in RUN (one shift-add or restoring-subtract step per cycle), then enter DONE.
REQ-020 SHALL assert wb_en for exactly one cycle, in DONE, which is cycle OPW+1 after the accept edge (cycle 17 at default); it SHALL return to IDLE on the next edge.
REQ-021 SHALL give a minimum accept-to-accept spacing of OPW+2 cycles.
REQ-022 SHALL, for multiply, produce wb_data = op_a * op_b as an unsigned full RESW-bit product with no truncation.
REQ-023 SHALL, for divide, produce wb_data = {remainder[OPW-1:0], quotient[OPW-1:0]}, both unsigned.
REQ-024 SHALL, for divide by zero, produce quotient all-ones and remainder = op_a, with unchanged latency and no error signal.
REQ-025 SHALL hold wb_data and wb_reg stable from DONE until the next accept; both are don't-care to consumers while wb_en is low.

Reset
REQ-026 SHALL, on a rst sample, enter IDLE and set wb_en=0, wb_data=0, wb_reg=0, busy=0 and in_ready=1 in the following cycle.
REQ-027 SHALL, on rst mid-RUN or in DONE, abort the operation with no wb_en pulse; rst takes priority over a simultaneous accept.

Configuration
REQ-028 SHALL compile the divide datapath only when MUL_DIV_UNIT_DIV_EN is defined.
REQ-029 SHALL, without MUL_DIV_UNIT_DIV_EN, still accept op=1 and pulse wb_en with normal latency, but with wb_data = 0; multiply behaviour is unchanged.

Structure
REQ-030 SHALL place the op encodings (MUL, DIV) and the FSM state enum in shared package mul_div_pkg.
REQ-031 SHALL keep the iterative step logic (accumulator, shift register, counter) in one sub-module, mul_div_datapath; mul_div_unit holds the FSM and handshake.

Verification
REQ-032 SHALL cover: MUL 3*5 accepted at cycle 0 -> wb_en at cycle 17 only, wb_data=0x0000000F, wb_reg=dest.
REQ-033 SHALL cover: MUL 0xFFFF*0xFFFF -> wb_data=0xFFFE0001.
REQ-034 SHALL cover: DIV 100/7 -> wb_data=0x0002000E; DIV 0x1234/0 -> wb_data=0x1234FFFF (both with DIV_EN defined); the same DIV ops without the macro -> wb_data=0 at cycle 17.
REQ-035 SHALL cover: rst asserted at cycle 8 of a MUL -> no wb_en pulse, in_ready=1 in the cycle after rst, all outputs zero.
REQ-036 SHALL cover: in_valid held high continuously with two requests -> second accepted at cycle 18, its wb_en at cycle 35, first result unaffected.
